// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg
//   Shared definitions for the PE wavefront launch scheduler: FSM state
//   encoding and the default array geometry used by pe_wave_sched and
//   pe_col_done_tracker.
package pe_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_FINISH = 2'd3
   } sched_state_t;

   localparam int PE_SCHED_NUM_COLS    = 32;
   localparam int PE_SCHED_NUM_PE_ROWS = 3;

endpackage

// File: rtl/pe_col_done_tracker.sv
// pe_col_done_tracker
//   Completion tracker for one PE column. After the column's launch strobe it
//   waits two cycles before it starts trusting the PE done levels (a PE may
//   still show a stale done from a previous run right after launch), then
//   accumulates one sticky seen bit per PE row.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : drop arming and seen bits (new run accepted)
//   launch      : one-cycle strobe, registered into col_start at this edge
//   en          : column enabled in the latched mask
//   pe_done     : per-row done levels of this column
//   col_ok      : column complete (or disabled); includes this cycle's capture
module pe_col_done_tracker
   import pe_sched_pkg::*;
#(
   parameter int NUM_PE_ROWS = PE_SCHED_NUM_PE_ROWS
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   clear,
   input  logic                   launch,
   input  logic                   en,
   input  logic [NUM_PE_ROWS-1:0] pe_done,
   output logic                   col_ok
);

   logic                   arm_p0;
   logic                   arm_p1;
   logic [NUM_PE_ROWS-1:0] seen;
   logic [NUM_PE_ROWS-1:0] seen_d;

   always_comb begin
      seen_d = seen | (pe_done & {NUM_PE_ROWS{arm_p1}});
   end

   // Look-ahead on seen_d lets the scheduler leave WAIT on the same edge
   // that captures the last done level.
   assign col_ok = !en || (&seen_d);

   // p0: launch edge seen; p1: armed from the second edge after launch on
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arm_p0 <= 1'b0;
         arm_p1 <= 1'b0;
         seen   <= '0;
      end else if (clear) begin
         arm_p0 <= 1'b0;
         arm_p1 <= 1'b0;
         seen   <= '0;
      end else begin
         arm_p0 <= launch;
         arm_p1 <= arm_p1 | arm_p0;
         seen   <= seen_d;
      end
   end

endmodule

// File: rtl/pe_wave_sched.sv
// pe_wave_sched
//   Launches a skewed wavefront across NUM_COLS PE columns, then waits until
//   every PE of every enabled column reports done and pulses done.
//   Optional watchdog enabled with macro PE_SCHED_TIMEOUT_EN.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   start        : level, sampled only in IDLE
//   abort        : ends any active run on the next edge, no done pulse
//   cfg_skew     : cycles between column launches (0 behaves as 1)
//   cfg_col_en   : active column mask
//   cfg_timeout  : watchdog limit in cycles (0 = off), used only with macro
//   pe_done      : per-PE done level, bit r*NUM_COLS+c
//   col_start    : one-cycle launch pulse per column
//   busy         : high outside IDLE
//   done         : one-cycle completion pulse
//   err_timeout  : sticky watchdog flag, cleared by the next accepted start
module pe_wave_sched
   import pe_sched_pkg::*;
#(
   parameter int NUM_COLS    = PE_SCHED_NUM_COLS,
   parameter int NUM_PE_ROWS = PE_SCHED_NUM_PE_ROWS,
   parameter int SKEW_W      = 4,
   parameter int TMO_W       = 16
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            start,
   input  logic                            abort,
   input  logic [SKEW_W-1:0]               cfg_skew,
   input  logic [NUM_COLS-1:0]             cfg_col_en,
   input  logic [TMO_W-1:0]                cfg_timeout,
   input  logic [NUM_PE_ROWS*NUM_COLS-1:0] pe_done,
   output logic [NUM_COLS-1:0]             col_start,
   output logic                            busy,
   output logic                            done,
   output logic                            err_timeout
);

   localparam int CIDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

   sched_state_t        state, state_d;
   logic [NUM_COLS-1:0] col_start_d;
   logic                busy_d, done_d, err_d;
   logic [CIDX_W-1:0]   col_idx, col_idx_d;
   logic [SKEW_W-1:0]   skew_cnt, skew_cnt_d;
   logic [SKEW_W-1:0]   skew_q;
   logic [SKEW_W-1:0]   skew_eff;
   logic [NUM_COLS-1:0] mask_q;
   logic [NUM_COLS-1:0] col_ok;
   logic                start_acc;
   logic                wd_hit;

   assign start_acc = (state == ST_IDLE) && start;
   assign skew_eff  = (skew_q == '0) ? SKEW_W'(1) : skew_q;

   // Run configuration is plain data: captured on an accepted start only.
   always_ff @(posedge clk) begin
      if (start_acc) begin
         skew_q <= cfg_skew;
         mask_q <= cfg_col_en;
      end
   end

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      logic [NUM_PE_ROWS-1:0] col_pe;
      for (genvar r = 0; r < NUM_PE_ROWS; r++) begin : g_row
         assign col_pe[r] = pe_done[r*NUM_COLS+c];
      end
      pe_col_done_tracker #(
         .NUM_PE_ROWS(NUM_PE_ROWS)
      ) u_trk (
         .clk    (clk),
         .resetn (resetn),
         .clear  (start_acc),
         .launch (col_start_d[c]),
         .en     (mask_q[c]),
         .pe_done(col_pe),
         .col_ok (col_ok[c])
      );
   end

`ifdef PE_SCHED_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_q;
   logic [TMO_W-1:0] wd_cnt;
   logic [TMO_W-1:0] wd_inc;
   logic             wd_active;

   always_ff @(posedge clk) begin
      if (start_acc) tmo_q <= cfg_timeout;
   end

   assign wd_active = (state == ST_LAUNCH) || (state == ST_WAIT);
   assign wd_inc    = wd_cnt + TMO_W'(1);
   // Fires on the edge where the count would reach the limit.
   assign wd_hit    = wd_active && (tmo_q != '0) && (wd_inc == tmo_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        wd_cnt <= '0;
      else if (start_acc) wd_cnt <= '0;
      else if (wd_active) wd_cnt <= wd_inc;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^cfg_timeout;
   assign wd_hit     = 1'b0;
`endif

   always_comb begin
      state_d     = state;
      col_start_d = '0;
      done_d      = 1'b0;
      err_d       = err_timeout;
      col_idx_d   = col_idx;
      skew_cnt_d  = skew_cnt;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LAUNCH;
               err_d      = 1'b0;
               col_idx_d  = '0;
               skew_cnt_d = '0;
            end
         end
         ST_LAUNCH: begin
            if (wd_hit) begin
               state_d = ST_FINISH;
               err_d   = 1'b1;
            end else if (mask_q == '0) begin
               state_d = ST_FINISH;
            end else if (skew_cnt == '0) begin
               // Disabled columns still use their slot, they just stay quiet.
               col_start_d[col_idx] = mask_q[col_idx];
               skew_cnt_d           = skew_eff - SKEW_W'(1);
               if (col_idx == CIDX_W'(NUM_COLS - 1)) state_d = ST_WAIT;
               else col_idx_d = col_idx + CIDX_W'(1);
            end else begin
               skew_cnt_d = skew_cnt - SKEW_W'(1);
            end
         end
         ST_WAIT: begin
            if (wd_hit) begin
               state_d = ST_FINISH;
               err_d   = 1'b1;
            end else if (&col_ok) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort && (state != ST_IDLE)) begin
         state_d     = ST_IDLE;
         col_start_d = '0;
         done_d      = 1'b0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         col_start   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         col_idx     <= '0;
         skew_cnt    <= '0;
      end else begin
         state       <= state_d;
         col_start   <= col_start_d;
         busy        <= busy_d;
         done        <= done_d;
         err_timeout <= err_d;
         col_idx     <= col_idx_d;
         skew_cnt    <= skew_cnt_d;
      end
   end

endmodule

// File: tb/tb_pe_wave_sched.sv
// tb_pe_wave_sched
//   Directed bench for pe_wave_sched at default geometry (32 columns, 3 rows).
//   Cycle k of a run is the cycle after the k-th edge past the start edge.
module tb_pe_wave_sched;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        abort;
   logic [3:0]  cfg_skew;
   logic [31:0] cfg_col_en;
   logic [15:0] cfg_timeout;
   logic [95:0] pe_done;
   logic [31:0] col_start;
   logic        busy;
   logic        done;
   logic        err_timeout;

   int tests = 0;
   int fails = 0;

   pe_wave_sched dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .abort      (abort),
      .cfg_skew   (cfg_skew),
      .cfg_col_en (cfg_col_en),
      .cfg_timeout(cfg_timeout),
      .pe_done    (pe_done),
      .col_start  (col_start),
      .busy       (busy),
      .done       (done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, got, exp);
      end
   endtask

   // One run: start with the given config, then check every cycle against a
   // small launch model. Negative cycle arguments mean "never".
   task automatic run_case(input string tag, input int skew, input logic [31:0] mask,
                           input int pe_dly, input bit hold1, input int stuck,
                           input int abort_k, input int restart_k,
                           input int exp_done_k, input int exp_err_k, input int ncyc);
      int s, j, l;
      logic [31:0] exp_cs;
      logic        exp_busy, exp_err, b;
      s = (skew == 0) ? 1 : skew;
      pe_done    = hold1 ? '1 : '0;
      cfg_skew   = 4'(skew);
      cfg_col_en = mask;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         exp_cs = '0;
         if (k >= 1) begin
            j = (k - 1) / s;
            if (((k - 1) % s == 0) && (j < 32) && mask[j]) exp_cs = 32'd1 << j;
         end
         if (abort_k >= 0 && k > abort_k) exp_cs = '0;
         exp_busy = (exp_done_k < 0 || k < exp_done_k) && (abort_k < 0 || k <= abort_k);
         exp_err  = (exp_err_k >= 0) && (k >= exp_err_k);
         chk({tag, "_col_start"}, k, col_start, exp_cs);
         chk({tag, "_done"}, k, {31'd0, done}, {31'd0, (k == exp_done_k)});
         chk({tag, "_busy"}, k, {31'd0, busy}, {31'd0, exp_busy});
         chk({tag, "_err"}, k, {31'd0, err_timeout}, {31'd0, exp_err});
         abort = (k == abort_k);
         start = (k == restart_k);
         for (int c = 0; c < 32; c++) begin
            l = 1 + c * s;
            for (int r = 0; r < 3; r++) begin
               b = hold1 || (pe_dly >= 0 && mask[c] && k >= l + pe_dly);
               if (r * 32 + c == stuck) b = 1'b0;
               pe_done[r*32+c] = b;
            end
         end
      end
      abort = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      cfg_skew    = 4'd0;
      cfg_col_en  = '0;
      cfg_timeout = 16'd100;
      pe_done     = '1;
      #12;
      chk("rst_col_start", 0, col_start, 32'd0);
      chk("rst_busy", 0, {31'd0, busy}, 32'd0);
      chk("rst_done", 0, {31'd0, done}, 32'd0);
      chk("rst_err", 0, {31'd0, err_timeout}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;

      // pe_done high since reset: last column seen 2 cycles after launch, done at 1+31*3+3
      run_case("held1", 3, 32'hFFFF_FFFF, -1, 1'b1, -1, -1, -1, 97, -1, 100);
      // skew 2, all columns, PEs finish 5 cycles after launch: done at 63+7
      run_case("allon", 2, 32'hFFFF_FFFF, 5, 1'b0, -1, -1, -1, 70, -1, 75);
      // skew 0 acts as 1, cols 4..7 only; start pulse mid-run is ignored
      run_case("mask_f0", 0, 32'h0000_00F0, 5, 1'b0, -1, -1, 20, 34, -1, 40);
      // empty mask: done at T+2, no launches
      run_case("mask0", 2, 32'h0, 5, 1'b0, -1, -1, -1, 2, -1, 5);
      // abort sampled at T+11: slot 5 suppressed, no done
      run_case("abort", 2, 32'hFFFF_FFFF, 5, 1'b0, -1, 10, -1, -1, -1, 80);
      run_case("after_abort", 2, 32'hFFFF_FFFF, 5, 1'b0, -1, -1, -1, 70, -1, 75);
`ifdef PE_SCHED_TIMEOUT_EN
      // PE row1/col0 never done: watchdog at 100 sets err, done one cycle later
      run_case("wdog", 2, 32'hFFFF_FFFF, 5, 1'b0, 32, -1, -1, 101, 100, 105);
`else
      // without the watchdog a stuck PE holds the run until abort
      run_case("stuck", 2, 32'hFFFF_FFFF, 5, 1'b0, 32, 120, -1, -1, -1, 125);
`endif
      run_case("rerun", 2, 32'hFFFF_FFFF, 5, 1'b0, -1, -1, -1, 70, -1, 75);

      // reset in the middle of a launch sequence
      pe_done    = '0;
      cfg_skew   = 4'd1;
      cfg_col_en = 32'hFFFF_FFFF;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
      end
      chk("midrst_pre_col_start", 10, col_start, 32'd1 << 9);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_col_start", 10, col_start, 32'd0);
      chk("midrst_busy", 10, {31'd0, busy}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         pe_done = '1;
         chk("postrst_done", k, {31'd0, done}, 32'd0);
         chk("postrst_busy", k, {31'd0, busy}, 32'd0);
         chk("postrst_col_start", k, col_start, 32'd0);
      end
      run_case("final", 1, 32'h0, -1, 1'b0, -1, -1, -1, 2, -1, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
